// File: rtl/reg_file_display_sys.sv
// Register-file subsystem: tick generator, debounced one-shot write strobe,
// 2^ADDR_W x DATA_W register file with two combinational read ports, and a
// multiplexed seven-segment scanner showing {r_data, s_data}.
// Optional feature macro: RFDS_ZERO_REG_EN (register 0 hard-wired to zero).
module reg_file_display_sys #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TICK_DIV    = 200000,
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_btn,
    input  logic [ADDR_W-1:0]        w_adr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        r_adr,
    input  logic [ADDR_W-1:0]        s_adr,
    output logic [DATA_W-1:0]        r_data,
    output logic [DATA_W-1:0]        s_data,
    output logic                     we_ack,
    output logic [(DATA_W/2)-1:0]    anodes,
    output logic [6:0]               seg
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned DIGITS = DATA_W / 2;
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tick;
    logic [1:0]             sync_q;
    logic [DEB_SAMPLES-1:0] hist_q, hist_d, hist_shift;
    logic                   deb_q, deb_d, deb_prev_q;
    logic                   armed_q, armed_d;
    logic                   wr_pulse, wr_en;
    logic                   we_ack_q;
    logic [DATA_W-1:0]      regs_q [DEPTH];
    logic [DIG_W-1:0]       dig_q;
    logic [2*DATA_W-1:0]    disp;
    logic [DIG_W+1:0]       nib_base;
    logic [3:0]             nib;
    logic [DIGITS-1:0]      anodes_q;
    logic [6:0]             seg_q;

    // Active-low hex pattern {a,b,c,d,e,f,g}, lowercase b and d
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h01;
            4'h1: p = 7'h4F;
            4'h2: p = 7'h12;
            4'h3: p = 7'h06;
            4'h4: p = 7'h4C;
            4'h5: p = 7'h24;
            4'h6: p = 7'h20;
            4'h7: p = 7'h0F;
            4'h8: p = 7'h00;
            4'h9: p = 7'h04;
            4'hA: p = 7'h08;
            4'hB: p = 7'h60;
            4'hC: p = 7'h31;
            4'hD: p = 7'h42;
            4'hE: p = 7'h30;
            default: p = 7'h38;
        endcase
        return p;
    endfunction

    assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign hist_shift = {hist_q[DEB_SAMPLES-2:0], sync_q[1]};

    // Next-state for tick counter, sample history, debounced level and arming.
    // Arming requires a genuinely low sample after reset, so a button held
    // through reset release cannot produce a write until released.
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        hist_d  = hist_q;
        deb_d   = deb_q;
        armed_d = armed_q;
        if (tick) begin
            hist_d = hist_shift;
            if (&hist_shift) begin
                deb_d = 1'b1;
            end else if (~|hist_shift) begin
                deb_d   = 1'b0;
                armed_d = 1'b1;
            end
        end
    end

    assign wr_pulse = deb_q & ~deb_prev_q & armed_q;

`ifdef RFDS_ZERO_REG_EN
    assign wr_en = wr_pulse & (w_adr != '0);
`else
    assign wr_en = wr_pulse;
`endif

    // Tick, synchroniser, debouncer and acknowledge state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            sync_q     <= '0;
            hist_q     <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            we_ack_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sync_q     <= {sync_q[0], we_btn};
            hist_q     <= hist_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            armed_q    <= armed_d;
            we_ack_q   <= wr_en;
        end
    end

    // Register storage, written only on the one-shot strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[w_adr] <= w_data;
        end
    end

    // Reads have no bypass: a commit becomes visible the following cycle
    assign r_data = regs_q[r_adr];
    assign s_data = regs_q[s_adr];
    assign we_ack = we_ack_q;

    assign disp     = {r_data, s_data};
    assign nib_base = {dig_q, 2'b00};
    assign nib      = disp[nib_base +: 4];

    // Scanner: latch the current digit's anode and pattern, then advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q    <= '0;
            anodes_q <= '1;
            seg_q    <= 7'h7F;
        end else if (tick) begin
            anodes_q <= ~(DIGITS'(1) << dig_q);
            seg_q    <= hex7(nib);
            dig_q    <= (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
    end

    assign anodes = anodes_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_reg_file_display_sys.sv
// Directed self-checking bench for reg_file_display_sys with TICK_DIV=4.
module tb_reg_file_display_sys;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned TD     = 4;
    localparam int unsigned DS     = 3;

`ifdef RFDS_ZERO_REG_EN
    localparam logic [31:0] ZERO_RD  = 32'h0;
    localparam int          ZERO_ACK = 2;
`else
    localparam logic [31:0] ZERO_RD  = 32'h1234;
    localparam int          ZERO_ACK = 3;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              we_btn;
    logic [ADDR_W-1:0] w_adr, r_adr, s_adr;
    logic [DATA_W-1:0] w_data, r_data, s_data;
    logic              we_ack;
    logic [7:0]        anodes;
    logic [6:0]        seg;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt  = 0;

    logic [7:0] scan_exp [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [7:0] dig_an   [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [6:0] dig_seg  [4] = '{7'h24, 7'h08, 7'h38, 7'h38};

    reg_file_display_sys #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TICK_DIV   (TD),
        .DEB_SAMPLES(DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we_btn(we_btn),
        .w_adr (w_adr),
        .w_data(w_data),
        .r_adr (r_adr),
        .s_adr (s_adr),
        .r_data(r_data),
        .s_data(s_data),
        .we_ack(we_ack),
        .anodes(anodes),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    // Count acknowledge pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (we_ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic press(input int hold_ticks);
        @(negedge clk) we_btn = 1'b1;
        repeat (hold_ticks * TD) @(negedge clk);
        we_btn = 1'b0;
        repeat (6 * TD) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset  = 1'b0;
        we_btn = 1'b0;
        w_adr  = '0;
        w_data = '0;
        r_adr  = '0;
        s_adr  = '0;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_anodes", 32'(anodes), 'hFF);
        chk("rst_seg", 32'(seg), 'h7F);
        chk("rst_we_ack", 32'(we_ack), 'h0);
        chk("rst_r_data", 32'(r_data), 'h0);
        chk("rst_s_data", 32'(s_data), 'h0);

        // Scan sequence from release: first lit digit at cycle TICK_DIV
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            repeat (TD) @(posedge clk);
            #1;
            chk($sformatf("scan_an%0d", i), 32'(anodes), 32'(scan_exp[i]));
            if (i == 0) chk("scan_seg0", 32'(seg), 'h01);
        end

        // Clean write
        ack_cnt = 0;
        w_adr   = 3'd3;
        w_data  = 16'hFFA5;
        r_adr   = 3'd3;
        s_adr   = 3'd3;
        press(10);
        chk("clean_ack", 32'(ack_cnt), 1);
        chk("clean_r", 32'(r_data), 'hFFA5);
        chk("clean_s", 32'(s_data), 'hFFA5);

        // Display digits 0..3 show s_data nibbles 5,A,F,F
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (anodes === 8'hFE) found = 1'b1;
        end
        chk("disp_found_d0", 32'(found), 1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (TD) @(negedge clk);
            chk($sformatf("disp_an%0d", d), 32'(anodes), 32'(dig_an[d]));
            chk($sformatf("disp_seg%0d", d), 32'(seg), 32'(dig_seg[d]));
        end

        // Bounce: toggle every tick, never DEB_SAMPLES equal samples
        w_data = 16'h0BAD;
        for (int i = 0; i < 8; i++) begin
            we_btn = ~we_btn;
            repeat (TD) @(negedge clk);
        end
        we_btn = 1'b0;
        repeat (6 * TD) @(negedge clk);
        chk("bounce_ack", 32'(ack_cnt), 1);
        chk("bounce_r", 32'(r_data), 'hFFA5);

        // Long hold with data changed after the commit
        w_adr  = 3'd5;
        w_data = 16'h1357;
        s_adr  = 3'd5;
        @(negedge clk) we_btn = 1'b1;
        repeat (10 * TD) @(negedge clk);
        w_data = 16'h2468;
        repeat (40 * TD) @(negedge clk);
        we_btn = 1'b0;
        repeat (6 * TD) @(negedge clk);
        chk("hold_ack", 32'(ack_cnt), 2);
        chk("hold_r", 32'(r_data), 'hFFA5);
        chk("hold_s", 32'(s_data), 'h1357);

        // Register 0
        w_adr  = 3'd0;
        w_data = 16'h1234;
        r_adr  = 3'd0;
        press(10);
        chk("zero_ack", 32'(ack_cnt), 32'(ZERO_ACK));
        chk("zero_r", 32'(r_data), ZERO_RD);

        // Reset mid-hold: held button must not write after release
        w_adr  = 3'd6;
        w_data = 16'h6666;
        r_adr  = 3'd6;
        @(negedge clk) we_btn = 1'b1;
        repeat (2 * TD) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_ack", 32'(we_ack), 0);
        chk("mid_rst_s", 32'(s_data), 0);
        ack_cnt = 0;
        reset   = 1'b1;
        repeat (12 * TD) @(negedge clk);
        chk("held_ack", 32'(ack_cnt), 0);
        chk("held_r", 32'(r_data), 0);
        we_btn = 1'b0;
        repeat (6 * TD) @(negedge clk);
        w_data = 16'h7777;
        press(10);
        chk("repress_ack", 32'(ack_cnt), 1);
        chk("repress_r", 32'(r_data), 'h7777);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_display_sys.md
# reg_file_display_sys

Parametrised register-file subsystem for the Nexys-class lab designs. It combines four pieces in one clock domain: a tick generator, a debounced one-shot write strobe, a 2^ADDR_W × DATA_W register file with two read ports, and a multiplexed seven-segment scanner that shows both read operands. It replaces the fixed 8×16 top-level arrangement that used a divided clock. All logic now runs on `clk`, and the slow rate is an enable tick.

## Interface
- `DATA_W`, 16: register width; must be a multiple of 4.
- `ADDR_W`, 3: address width; depth = 2^ADDR_W.
- `TICK_DIV`, 200000: `clk` cycles per tick (500 Hz at 100 MHz); must be ≥ 2.
- `DEB_SAMPLES`, 3: consecutive equal tick samples needed to change the debounced level; must be ≥ 2.
- Derived: `DIGITS` = DATA_W/2 (nibbles of {R,S}).

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `reset`, in, 1: asynchronous, active-low reset.
- `we_btn`, in, 1: raw, bouncy write button (asynchronous to `clk`).
- `w_adr`, in, ADDR_W: write address.
- `w_data`, in, DATA_W: write data.
- `r_adr`, in, ADDR_W: read port R address.
- `s_adr`, in, ADDR_W: read port S address.
- `r_data`, out, DATA_W: register[`r_adr`], combinational read.
- `s_data`, out, DATA_W: register[`s_adr`], combinational read.
- `we_ack`, out, 1: one-cycle pulse when a write commits.
- `anodes`, out, DIGITS: digit enables, active-low, registered.
- `seg`, out, 7: {a,b,c,d,e,f,g}, active-low, registered.

## Operation
- Tick generator:
  - Counter 0..TICK_DIV-1. `tick`=1 for exactly one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
- Input sync:
  - `we_btn` passes through a 2-flop synchroniser before any other use.
- Debouncer:
  - On each tick, shift the synchronised button into a DEB_SAMPLES-bit history.
  - The debounced level goes to 1 only when all samples are 1, and to 0 only when all samples are 0. Otherwise it holds.
- One-shot:
  - `wr_pulse` = rising edge of the debounced level, exactly one `clk` cycle per press, regardless of hold time.
- Register file:
  - On a `clk` edge where `wr_pulse`=1, reg[`w_adr`] ← `w_data`.
  - `w_adr` and `w_data` are sampled in that cycle only.
  - `we_ack` is the registered `wr_pulse`, asserted the cycle after the commit.
- Read ports:
  - Pure combinational. R and S may address the same register or the write target.
  - A read in the commit cycle returns the old value; the new value is visible from the next cycle. No bypass.
- Scanner:
  - Digit index `dig` 0..DIGITS-1, advances on each tick and wraps DIGITS-1→0.
  - Display word D = {r_data, s_data}. Digit `dig` shows nibble D[4·dig+3:4·dig], so digit 0 = s_data[3:0] and digit DIGITS-1 = r_data[DATA_W-1:DATA_W-4].
  - Registered on the tick: `anodes` = ~(1<<dig); `seg` = standard hex pattern of the nibble, 0–F, with lowercase b and d, active-low.
- Reset (asynchronous, `reset`=0). All of the following hold while reset is low and on release:
  - Tick counter = 0, `dig` = 0.
  - Sync flops, history and debounced level all 0.
  - All registers 0, `we_ack` = 0.
  - `anodes` = all 1s (blank), `seg` = 7'h7F.
- Reset mid-operation: a reset asserted during a bounce or a hold discards the history. A button still held at release does not write until it is released and pressed again, because the level must go 1 from a 0 history.

## Timing
- Press latency: the first tick after the synchronised input is stable high, plus DEB_SAMPLES-1 further ticks, gives the debounced rise. `wr_pulse` asserts the following cycle, and `we_ack` one cycle after that.
- A bounce shorter than DEB_SAMPLES consecutive ticks never produces a write.
- The scanner refresh period is DIGITS·TICK_DIV cycles. The first lit digit appears on the first tick after reset release, at cycle TICK_DIV.
- A register change is reflected on the display at the next scan of the affected digits. No display tearing within a digit.

## Configuration
- `RFDS_ZERO_REG_EN`
  - Defined: register 0 is hard-wired to 0. Writes to address 0 are discarded and `we_ack` does not pulse for them. Reads of address 0 return 0.
  - Undefined: register 0 is an ordinary register.

## Test plan
- Reset: hold `reset`=0 for 5 cycles with TICK_DIV=4 → `anodes`=8'hFF, `seg`=7'h7F, `we_ack`=0, `r_data`=`s_data`=0; after release, first tick gives `anodes`=8'hFE, `seg`=7'h01 (digit "0").
- Clean write: `w_adr`=3, `w_data`=16'hFFA5, `we_btn` held high for 10 ticks → exactly one `we_ack` pulse; with `r_adr`=3, `r_data`=16'hFFA5; digits 4..7 scan A,5? No: with `s_adr`=3, digits 0..3 show 5,A,F,F.
- Bounce: toggle `we_btn` every tick for 8 ticks (DEB_SAMPLES=3), then hold low → no `we_ack`, reg[3] unchanged.
- Long hold: hold `we_btn` for 50 ticks while changing `w_data` afterwards → single write of the value present at the pulse cycle.
- Scan wrap: after reset, count 9 ticks → `anodes` sequence FE,FD,…,7F,FE.
- Zero register: write 16'h1234 to address 0 → with `RFDS_ZERO_REG_EN` defined, `r_data`=0 and no `we_ack`; without it, `r_data`=16'h1234 and one `we_ack`. Also assert `reset` mid-hold → no write after release until the button is re-pressed.
